// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) helpers for the iterative cores.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } aes_state_e;

    localparam int KEY_W     = 256;
    localparam int BLK_W     = 128;
    localparam int MAX_WORDS = 60;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Key length in 32-bit words; mux=11 falls back to AES-128.
    function automatic logic [3:0] nk_of(input logic [1:0] m);
        case (m)
            2'b01:   nk_of = 4'd6;
            2'b10:   nk_of = 4'd8;
            default: nk_of = 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] m);
        case (m)
            2'b01:   nr_of = 4'd12;
            2'b10:   nr_of = 4'd14;
            default: nr_of = 4'd10;
        endcase
    endfunction

    // Total schedule words 4*(Nr+1).
    function automatic logic [5:0] nw_of(input logic [1:0] m);
        case (m)
            2'b01:   nw_of = 6'd52;
            2'b10:   nw_of = 6'd60;
            default: nw_of = 6'd44;
        endcase
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] base;
        base = 11'd2047 - {b, 3'b000};
        sbox = SBOX_TBL[base -: 8];
    endfunction

    // Multiply by x modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One MixColumns column, byte a0 in bits [31:24].
    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        mix_col = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                   a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                   a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                   xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_encrypt_iter_sbox.sv
// Combinational forward S-box lookup, one byte.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);

    assign y_o = sbox(a_i);

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128/192/256 encryption: key expansion one word per cycle,
// then one round per cycle out of the stored 60-word schedule.
module aes_encrypt_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] key,
    input  logic [1:0]   mux,
    input  logic [127:0] in_state,
    output logic [127:0] out_state,
    output logic [3:0]   counter,
    output logic         busy,
    output logic         done
);

    aes_state_e   state_q, state_d;
    logic [1:0]   mux_q;
    logic [127:0] in_q, st_q, out_q;
    logic [31:0]  w_q [MAX_WORDS];
    logic [5:0]   i_q;
    logic [2:0]   ki_q;
    logic [3:0]   rc_q, rnd_q;
    logic         busy_q, done_q;

    logic [3:0]   nk, nr;
    logic [5:0]   nw;
    logic [31:0]  prev_w, back_w, sw_in, sw_out, new_w;
    logic [127:0] sb, sr, mc, rk, round_out;

    assign nk = nk_of(mux_q);
    assign nr = nr_of(mux_q);
    assign nw = nw_of(mux_q);

    // Key expansion: ki_q tracks i mod Nk and rc_q tracks i / Nk.
    assign prev_w = w_q[i_q - 6'd1];
    assign back_w = w_q[i_q - {2'b00, nk}];
    assign sw_in  = (ki_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (.a_i(sw_in[31-8*g -: 8]), .y_o(sw_out[31-8*g -: 8]));
    end

    // Next schedule word selection for the three FIPS-197 cases.
    always_comb begin
        new_w = back_w ^ prev_w;
        if (ki_q == 3'd0)
            new_w = back_w ^ sw_out ^ {rcon(rc_q), 24'h0};
        else if (nk == 4'd8 && ki_q == 3'd4)
            new_w = back_w ^ sw_out;
    end

    // Round datapath: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey.
    for (genvar g = 0; g < 16; g++) begin : g_subbytes
        aes_sbox u_sbox (.a_i(st_q[127-8*g -: 8]), .y_o(sb[127-8*g -: 8]));
    end

    // ShiftRows: row r of column c takes row r of column (c+r) mod 4.
    always_comb begin
        sr = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
        assign rk[127-32*c -: 32] = w_q[{rnd_q, 2'b00} + 6'(c)];
    end

    assign round_out = ((rnd_q == nr) ? sr : mc) ^ rk;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = KEYEXP;
            KEYEXP:  if (i_q == nw - 6'd1) state_d = ROUND;
            ROUND:   if (rnd_q == nr) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath, schedule and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mux_q  <= '0;
            in_q   <= '0;
            st_q   <= '0;
            out_q  <= '0;
            i_q    <= '0;
            ki_q   <= '0;
            rc_q   <= '0;
            rnd_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            for (int k = 0; k < MAX_WORDS; k++) w_q[k] <= '0;
        end else begin
            done_q <= 1'b0;
            busy_q <= (state_q == KEYEXP) || (state_q == ROUND);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mux_q <= mux;
                        in_q  <= in_state;
                        for (int k = 0; k < 8; k++) w_q[k] <= key[255-32*k -: 32];
                        i_q   <= {2'b00, nk_of(mux)};
                        ki_q  <= 3'd0;
                        rc_q  <= 4'd1;
                        rnd_q <= 4'd0;
                    end
                end
                KEYEXP: begin
                    w_q[i_q] <= new_w;
                    i_q      <= i_q + 6'd1;
                    if ({1'b0, ki_q} == nk - 4'd1) begin
                        ki_q <= 3'd0;
                        rc_q <= rc_q + 4'd1;
                    end else begin
                        ki_q <= ki_q + 3'd1;
                    end
                end
                ROUND: begin
                    st_q <= (rnd_q == 4'd0) ? (in_q ^ rk) : round_out;
                    if (rnd_q != nr) rnd_q <= rnd_q + 4'd1;
                end
                DONE: begin
                    out_q  <= st_q;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_state = out_q;
    assign counter   = (state_q == ROUND) ? rnd_q : 4'd0;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Bench for aes_encrypt_iter using the FIPS-197 appendix C vectors.
module tb_aes_encrypt_iter;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [255:0] key;
    logic [1:0]   mux;
    logic [127:0] in_state;
    logic [127:0] out_state;
    logic [3:0]   counter;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q[$];

    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_encrypt_iter dut (
        .clk(clk), .reset(reset), .start(start), .key(key), .mux(mux),
        .in_state(in_state), .out_state(out_state), .counter(counter),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Issue one request at a negedge, push its expected ciphertext and check
    // latency, busy shape, result and the single-cycle done pulse.
    task automatic run_one(input logic [255:0] k, input logic [1:0] m, input logic [127:0] p,
                           input logic [127:0] exp, input int lat, input string name);
        int n;
        logic [127:0] want;
        key = k; mux = m; in_state = p; start = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        key = '1; in_state = '1; mux = 2'b00;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_after_accept got %b want 1", name, busy);
                end
            end
        end
        checks++;
        if (n != lat) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", name, n, lat);
        end
        if (done === 1'b1) begin
            want = exp_q.pop_front();
            checks++;
            if (out_state !== want) begin
                errors++;
                $display("FAIL %s out_state got %h want %h", name, out_state, want);
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_at_done got %b want 0", name, busy);
            end
        end else begin
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_width got %b want 0", name, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; key = '0; mux = 2'b00; in_state = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_state !== 128'h0 || counter !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs got %h/%0d/%b/%b want 0/0/0/0", out_state, counter, busy, done);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_aes128(); run_one(K128, 2'b00, PT, CT1, 52, "c1_aes128"); endtask
    task automatic test_aes192(); run_one(K192, 2'b01, PT, CT2, 60, "c2_aes192"); endtask
    task automatic test_aes256(); run_one(K256, 2'b10, PT, CT3, 68, "c3_aes256"); endtask
    task automatic test_mux11();  run_one(K128, 2'b11, PT, CT1, 52, "mux11"); endtask

    task automatic test_abort();
        int n, dones;
        key = K128; mux = 2'b00; in_state = PT; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (counter !== 4'd5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (counter !== 4'd5) begin
            errors++;
            $display("FAIL abort reach_counter5 got %0d want 5", counter);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (out_state !== 128'h0 || counter !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort outputs got %h/%0d/%b/%b want 0/0/0/0", out_state, counter, busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL abort spurious_done got %0d want 0", dones);
        end
        run_one(K128, 2'b00, PT, CT1, 52, "after_abort");
    endtask

    task automatic test_ignored_start();
        int n, first, dones;
        logic [127:0] got, want;
        key = K128; mux = 2'b00; in_state = PT; start = 1'b1;
        exp_q.push_back(CT1);
        @(negedge clk);
        start = 1'b0;
        n = 0; first = -1; dones = 0; got = '0;
        while (n < 160) begin
            @(negedge clk);
            n++;
            if (n == 10) begin
                key = K256; mux = 2'b10; in_state = ~PT; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                dones++;
                if (first < 0) begin
                    first = n;
                    got = out_state;
                end
            end
        end
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL ignored_start out_state got %h want %h", got, want);
        end
        checks++;
        if (first != 52) begin
            errors++;
            $display("FAIL ignored_start latency got %0d want 52", first);
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL ignored_start done_count got %0d want 1", dones);
        end
    endtask

    task automatic test_back_to_back();
        run_one(K128, 2'b00, PT, CT1, 52, "b2b_first");
        run_one(K256, 2'b10, PT, CT3, 68, "b2b_second");
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_abort();
        test_ignored_start();
        test_mux11();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
